// File: rtl/systolic_ctrl.sv
// Sequencer for an NxN output-stationary systolic array: buffers A and B,
// streams them skewed into the array edges, then returns C row by row.
module systolic_ctrl #(
  parameter int DATA_W    = 16,
  parameter int ACC_W     = 32,
  parameter int N         = 4,
  parameter int DRAIN_CYC = 4
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              ld_valid,
  output logic                              ld_ready,
  input  logic                              ld_sel,
  input  logic [$clog2(N)-1:0]              ld_row,
  input  logic [$clog2(N)-1:0]              ld_col,
  input  logic [DATA_W-1:0]                 ld_data,
  input  logic                              start,
  output logic                              busy,
  output logic                              done,
  output logic                              arr_clear,
  output logic                              arr_valid,
  output logic [N-1:0][DATA_W-1:0]          arr_a,
  output logic [N-1:0][DATA_W-1:0]          arr_b,
  input  logic [N-1:0][N-1:0][ACC_W-1:0]    arr_c,
  output logic                              res_valid,
  input  logic                              res_ready,
  output logic [$clog2(N)-1:0]              res_row,
  output logic [N-1:0][ACC_W-1:0]           res_data
);

  localparam int RW = $clog2(N);
  localparam int FW = $clog2(3*N-1);
  localparam int DW = $clog2(DRAIN_CYC+1);
  localparam logic [FW-1:0] FEED_LAST  = FW'(3*N-3);
  localparam logic [DW-1:0] DRAIN_LAST = DW'(DRAIN_CYC-1);
  localparam logic [RW-1:0] ROW_LAST   = RW'(N-1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_FEED,
    S_DRAIN,
    S_OUT
  } state_t;

  state_t state_reg, state_next;
  logic [FW-1:0] feed_cnt_reg, feed_cnt_next;
  logic [DW-1:0] drain_cnt_reg, drain_cnt_next;
  logic [RW-1:0] row_reg, row_next;
  logic          last_accept;

  logic [N-1:0][N-1:0][DATA_W-1:0] a_buf_reg;
  logic [N-1:0][N-1:0][DATA_W-1:0] b_buf_reg;
  logic [N-1:0][N-1:0][ACC_W-1:0]  cbuf_reg;

  logic [N-1:0][DATA_W-1:0] a_feed, b_feed;
  logic [N-1:0][ACC_W-1:0]  res_data_next;
  logic                     ld_wr;
  logic                     capture;

  assign ld_wr   = ld_valid && (state_reg == S_IDLE);
  assign capture = (state_reg == S_DRAIN) && (drain_cnt_reg == DRAIN_LAST);

  // Operand buffers: written only while idle, kept across runs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_buf_reg <= '0;
      b_buf_reg <= '0;
    end else if (ld_wr) begin
      for (int i = 0; i < N; i++) begin
        for (int j = 0; j < N; j++) begin
          if (ld_row == RW'(i) && ld_col == RW'(j)) begin
            if (ld_sel) b_buf_reg[i][j] <= ld_data;
            else        a_buf_reg[i][j] <= ld_data;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cbuf_reg <= '0;
    else if (capture) cbuf_reg <= arr_c;
  end

  always_comb begin
    state_next     = state_reg;
    feed_cnt_next  = feed_cnt_reg;
    drain_cnt_next = drain_cnt_reg;
    row_next       = row_reg;
    last_accept    = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (start) state_next = S_CLEAR;
      end
      S_CLEAR: begin
        state_next    = S_FEED;
        feed_cnt_next = '0;
      end
      S_FEED: begin
        if (feed_cnt_reg == FEED_LAST) begin
          state_next     = S_DRAIN;
          drain_cnt_next = '0;
        end else begin
          feed_cnt_next = feed_cnt_reg + FW'(1);
        end
      end
      S_DRAIN: begin
        if (drain_cnt_reg == DRAIN_LAST) begin
          state_next = S_OUT;
          row_next   = '0;
        end else begin
          drain_cnt_next = drain_cnt_reg + DW'(1);
        end
      end
      S_OUT: begin
        if (res_ready) begin
          if (row_reg == ROW_LAST) begin
            state_next  = S_IDLE;
            last_accept = 1'b1;
          end else begin
            row_next = row_reg + RW'(1);
          end
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Skew: element (i,j) enters both edges on feed step i+j, so an
  // out-of-range index simply never matches and the edge stays zero.
  always_comb begin
    a_feed = '0;
    b_feed = '0;
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        if (int'(feed_cnt_next) == i + j) begin
          a_feed[i] = a_buf_reg[i][j];
          b_feed[j] = b_buf_reg[i][j];
        end
      end
    end
  end

  // Row 0 is presented in the same cycle the capture lands, so bypass it.
  always_comb begin
    res_data_next = cbuf_reg[row_next];
    if (state_reg == S_DRAIN) res_data_next = arr_c[0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= S_IDLE;
      feed_cnt_reg  <= '0;
      drain_cnt_reg <= '0;
      row_reg       <= '0;
      ld_ready      <= 1'b1;
      busy          <= 1'b0;
      done          <= 1'b0;
      arr_clear     <= 1'b0;
      arr_valid     <= 1'b0;
      arr_a         <= '0;
      arr_b         <= '0;
      res_valid     <= 1'b0;
      res_row       <= '0;
      res_data      <= '0;
    end else begin
      state_reg     <= state_next;
      feed_cnt_reg  <= feed_cnt_next;
      drain_cnt_reg <= drain_cnt_next;
      row_reg       <= row_next;
      ld_ready      <= (state_next == S_IDLE);
      busy          <= (state_next != S_IDLE);
      done          <= last_accept;
      arr_clear     <= (state_next == S_CLEAR);
      arr_valid     <= (state_next == S_FEED);
      arr_a         <= (state_next == S_FEED) ? a_feed : '0;
      arr_b         <= (state_next == S_FEED) ? b_feed : '0;
      res_valid     <= (state_next == S_OUT);
      res_row       <= (state_next == S_OUT) ? row_next : '0;
      res_data      <= (state_next == S_OUT) ? res_data_next : '0;
    end
  end

endmodule

// File: tb/tb_systolic_ctrl.sv
// Bench for systolic_ctrl: a behavioural array drives arr_c, a matrix-product
// reference fills a scoreboard, and a monitor checks returned rows.
module tb_systolic_ctrl;

  localparam int DATA_W    = 16;
  localparam int ACC_W     = 32;
  localparam int N         = 4;
  localparam int DRAIN_CYC = 4;
  localparam int RW        = $clog2(N);

  typedef logic [N-1:0][ACC_W-1:0]  row_t;
  typedef logic [N-1:0][DATA_W-1:0] edge_t;
  typedef struct {
    int   row;
    row_t data;
  } exp_t;

  logic                           clk;
  logic                           rst_n;
  logic                           ld_valid;
  logic                           ld_ready;
  logic                           ld_sel;
  logic [RW-1:0]                  ld_row;
  logic [RW-1:0]                  ld_col;
  logic [DATA_W-1:0]              ld_data;
  logic                           start;
  logic                           busy;
  logic                           done;
  logic                           arr_clear;
  logic                           arr_valid;
  edge_t                          arr_a;
  edge_t                          arr_b;
  logic [N-1:0][N-1:0][ACC_W-1:0] arr_c;
  logic                           res_valid;
  logic                           res_ready;
  logic [RW-1:0]                  res_row;
  row_t                           res_data;

  systolic_ctrl #(
    .DATA_W(DATA_W), .ACC_W(ACC_W), .N(N), .DRAIN_CYC(DRAIN_CYC)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_sel(ld_sel),
    .ld_row(ld_row), .ld_col(ld_col), .ld_data(ld_data),
    .start(start), .busy(busy), .done(done),
    .arr_clear(arr_clear), .arr_valid(arr_valid),
    .arr_a(arr_a), .arr_b(arr_b), .arr_c(arr_c),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_row(res_row), .res_data(res_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [DATA_W-1:0] a_m [N][N];
  logic [DATA_W-1:0] b_m [N][N];
  exp_t sb_q[$];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic row_t ref_row(input int r);
    row_t v;
    logic [ACC_W-1:0] s;
    for (int c = 0; c < N; c++) begin
      s = '0;
      for (int k = 0; k < N; k++) s = s + ACC_W'(a_m[r][k]) * ACC_W'(b_m[k][c]);
      v[c] = s;
    end
    return v;
  endfunction

  // Behavioural array: PE(i,j) sees the left edge delayed by j and the top edge delayed by i.
  edge_t a_hist[$];
  edge_t b_hist[$];

  function automatic logic [N-1:0][N-1:0][ACC_W-1:0] array_result();
    logic [N-1:0][N-1:0][ACC_W-1:0] m;
    logic [ACC_W-1:0] acc;
    int t_len;
    t_len = a_hist.size();
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        acc = '0;
        for (int t = 0; t < t_len + 2*N; t++) begin
          if (t - j >= 0 && t - j < t_len && t - i >= 0 && t - i < t_len)
            acc = acc + ACC_W'(a_hist[t-j][i]) * ACC_W'(b_hist[t-i][j]);
        end
        m[i][j] = acc;
      end
    end
    return m;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_hist.delete();
      b_hist.delete();
      arr_c <= '0;
    end else if (arr_clear) begin
      a_hist.delete();
      b_hist.delete();
      arr_c <= '0;
    end else if (arr_valid) begin
      a_hist.push_back(arr_a);
      b_hist.push_back(arr_b);
      arr_c <= array_result();
    end
  end

  // Edge feed check against the skew rule, with a log for directed checks.
  int    feed_k = 0;
  edge_t feed_a_log [3*N];
  always @(negedge clk) begin
    edge_t ea, eb;
    if (rst_n) begin
      if (arr_clear) feed_k = 0;
      if (arr_valid) begin
        ea = '0;
        eb = '0;
        for (int i = 0; i < N; i++) begin
          if (feed_k - i >= 0 && feed_k - i < N) ea[i] = a_m[i][feed_k-i];
          if (feed_k - i >= 0 && feed_k - i < N) eb[i] = b_m[feed_k-i][i];
        end
        chk("feed_a", arr_a, ea);
        chk("feed_b", arr_b, eb);
        if (feed_k < 3*N) feed_a_log[feed_k] = arr_a;
        feed_k++;
      end
    end
  end

  // Result monitor: scoreboard pops, stall stability, done exclusivity.
  logic  stall_prev = 1'b0;
  logic [RW-1:0] stall_row;
  row_t  stall_data;
  exp_t  mon_e;
  always @(negedge clk) begin
    if (!rst_n) begin
      stall_prev = 1'b0;
    end else begin
      if (done) chk("done_with_res_valid", res_valid, 0);
      if (res_valid && stall_prev) begin
        chk("stall_row", res_row, stall_row);
        chk("stall_data", res_data, stall_data);
      end
      stall_prev = res_valid && !res_ready;
      stall_row  = res_row;
      stall_data = res_data;
      if (res_valid && res_ready) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_row: got row %0d, none expected", res_row);
        end else begin
          mon_e = sb_q.pop_front();
          chk("res_row", res_row, mon_e.row);
          chk("res_data", res_data, mon_e.data);
          $display("row %0d accepted data=0x%0h", res_row, res_data);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input bit sel, input int r, input int c, input logic [DATA_W-1:0] d);
    ld_valid = 1'b1;
    ld_sel   = sel;
    ld_row   = RW'(r);
    ld_col   = RW'(c);
    ld_data  = d;
    tick();
    ld_valid = 1'b0;
    if (sel) b_m[r][c] = d;
    else     a_m[r][c] = d;
  endtask

  // mode 0: always ready, 1: random ready, 2: stall 5 cycles at row 1 then toggle.
  task automatic run(input int mode, input bit inject);
    exp_t tmp;
    int   c, first_rv, done_cnt, stalls;
    bit   tog;
    for (int r = 0; r < N; r++) begin
      tmp.row  = r;
      tmp.data = ref_row(r);
      sb_q.push_back(tmp);
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    c = 1;
    chk("busy_cycle1", busy, 1);
    chk("clear_cycle1", arr_clear, 1);
    first_rv = -1;
    done_cnt = 0;
    stalls   = 0;
    tog      = 1'b0;
    while (c < 400) begin
      if (res_valid && first_rv < 0) first_rv = c;
      if (done) done_cnt++;
      if (done_cnt > 0 && !done) break;
      if (inject && c == 5) begin
        chk("ld_ready_busy", ld_ready, 0);
        ld_valid = 1'b1;
        ld_sel   = 1'b0;
        ld_row   = '0;
        ld_col   = '0;
        ld_data  = 16'd7;
        start    = 1'b1;
      end else if (inject && c == 6) begin
        ld_valid = 1'b0;
        start    = 1'b0;
      end
      case (mode)
        1: res_ready = 1'($urandom_range(0, 1));
        2: begin
          if (res_valid && res_row == 1 && stalls < 5) begin
            res_ready = 1'b0;
            stalls++;
          end else begin
            res_ready = tog;
            tog = !tog;
          end
        end
        default: res_ready = 1'b1;
      endcase
      tick();
      c++;
    end
    res_ready = 1'b1;
    chk("run_completed", (c < 400), 1);
    chk("first_res_valid_cycle", first_rv, 16);
    chk("done_pulses", done_cnt, 1);
    chk("feed_cycles", feed_k, 3*N-2);
    chk("scoreboard_empty", sb_q.size(), 0);
    repeat (3) tick();
    chk("idle_after_run", busy, 0);
    $display("run mode=%0d inject=%0d first_res_valid=%0d done_pulses=%0d", mode, inject, first_rv, done_cnt);
  endtask

  initial begin
    edge_t ev;
    rst_n     = 1'b0;
    ld_valid  = 1'b0;
    ld_sel    = 1'b0;
    ld_row    = '0;
    ld_col    = '0;
    ld_data   = '0;
    start     = 1'b0;
    res_ready = 1'b1;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        a_m[i][j] = '0;
        b_m[i][j] = '0;
      end
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_arr_clear", arr_clear, 0);
    chk("rst_arr_valid", arr_valid, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_arr_a", arr_a, 0);
    chk("rst_arr_b", arr_b, 0);
    chk("rst_res_row", res_row, 0);
    chk("rst_res_data", res_data, 0);
    chk("rst_ld_ready", ld_ready, 1);
    rst_n = 1'b1;
    tick();

    // Identity times B returns B.
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) begin
        load(1'b0, r, c, (r == c) ? 16'd1 : 16'd0);
        load(1'b1, r, c, DATA_W'(4*r + c + 1));
      end
    run(0, 1'b0);

    // Skew pattern.
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) begin
        load(1'b0, r, c, DATA_W'(16*r + c));
        load(1'b1, r, c, 16'd0);
      end
    run(0, 1'b0);
    ev[0] = 16'd3;
    ev[1] = 16'd18;
    ev[2] = 16'd33;
    ev[3] = 16'd48;
    chk("skew_k3", feed_a_log[3], ev);
    ev = '0;
    chk("skew_k0", feed_a_log[0], ev);

    // Backpressure on random operands.
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) begin
        load(1'b0, r, c, DATA_W'($urandom));
        load(1'b1, r, c, DATA_W'($urandom));
      end
    run(2, 1'b0);

    // Writes and start during FEED are ignored; the rerun uses the old A.
    run(0, 1'b1);
    run(0, 1'b0);

    // Random ready with fresh operands.
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) begin
        load(1'b0, r, c, DATA_W'($urandom));
        load(1'b1, r, c, DATA_W'($urandom));
      end
    run(1, 1'b0);

    // Overflow: each C element wraps to 0xFFF80004.
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) begin
        load(1'b0, r, c, 16'hFFFF);
        load(1'b1, r, c, 16'hFFFF);
      end
    run(0, 1'b0);

    // Reset mid-FEED, then a run that must see cleared buffers.
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    chk("pre_reset_arr_valid", arr_valid, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_busy", busy, 0);
    chk("async_rst_arr_valid", arr_valid, 0);
    chk("async_rst_arr_a", arr_a, 0);
    chk("async_rst_res_valid", res_valid, 0);
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        a_m[i][j] = '0;
        b_m[i][j] = '0;
      end
    tick();
    rst_n = 1'b1;
    tick();
    chk("post_rst_ld_ready", ld_ready, 1);
    chk("post_rst_busy", busy, 0);
    run(0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/systolic_ctrl.md
Name: systolic_ctrl

Overview:
- Sequencer for the NxN output-stationary systolic array.
- Holds one A and one B operand matrix in local register buffers.
- On start it clears the array accumulators, streams skewed rows of A (left edge) and columns of B (top edge), and waits for the pipeline to drain.
- It then captures the NxN result and returns it row by row over a valid/ready port.

Parameters:
- DATA_W, 16, operand element width
- ACC_W, 32, accumulator/result element width
- N, 4, array dimension (N >= 2)
- DRAIN_CYC, 4, cycles waited after the last feed before capturing results (>= 1)

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- ld_valid  in  1  operand write strobe
- ld_ready  out  1  operand write accepted (high only in IDLE)
- ld_sel  in  1  0 = write A, 1 = write B
- ld_row  in  $clog2(N)  element row index
- ld_col  in  $clog2(N)  element column index
- ld_data  in  DATA_W  element value
- start  in  1  begin a multiply (sampled only in IDLE)
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse after the last result row is accepted
- arr_clear  out  1  accumulator clear to the array
- arr_valid  out  1  array valid_in
- arr_a  out  [N] x DATA_W  left-edge inputs, one per row
- arr_b  out  [N] x DATA_W  top-edge inputs, one per column
- arr_c  in  [N][N] x ACC_W  array result matrix
- res_valid  out  1  result row available
- res_ready  in  1  consumer accepts the row
- res_row  out  $clog2(N)  index of the presented row
- res_data  out  [N] x ACC_W  result row: C[res_row][0..N-1]

Behaviour:
- Reset (async assert, sync release):
  - State = IDLE.
  - busy, done, arr_clear, arr_valid, res_valid = 0; arr_a, arr_b, res_row, res_data = 0.
  - Operand buffers and result registers cleared to 0.
- All outputs are registered.
- Load:
  - In IDLE, ld_ready = 1; ld_valid writes ld_data into A[ld_row][ld_col] or B[ld_row][ld_col], selected by ld_sel.
  - Outside IDLE, ld_ready = 0 and writes are ignored.
  - Buffers persist across runs; only reset clears them.
- FSM: IDLE -> CLEAR -> FEED -> DRAIN -> OUT -> IDLE.
  - IDLE: start = 1 -> CLEAR. start outside IDLE is ignored.
  - ld_valid and start in the same IDLE cycle: the write commits, and the run uses the updated buffer.
  - CLEAR: exactly 1 cycle. arr_clear = 1, arr_valid = 0. -> FEED.
  - FEED: 3N-2 cycles, feed counter k = 0..3N-3, arr_valid = 1 every cycle.
    - arr_a[i] = A[i][k-i] when 0 <= k-i < N, else 0.
    - arr_b[j] = B[k-j][j] when 0 <= k-j < N, else 0.
    - After k = 3N-3 -> DRAIN.
  - DRAIN: DRAIN_CYC cycles, arr_valid = 0, arr_a/arr_b = 0.
    - On the last drain cycle, arr_c is registered into the result buffer. -> OUT.
  - OUT: res_valid = 1, res_row = r, res_data = Cbuf[r], starting at r = 0.
    - r increments on each cycle with res_valid && res_ready.
    - res_data is stable while res_ready = 0.
    - Acceptance of r = N-1 -> done = 1 for the next cycle, res_valid = 0, state IDLE.
- Latency, start sampled at cycle 0 (N=4, DRAIN_CYC=4):
  - busy = 1 from cycle 1; arr_clear in cycle 1.
  - arr_valid cycles 2..11.
  - res_valid first asserted at cycle 16.
- Widths:
  - Feed counter is $clog2(3N-1) bits; drain counter is $clog2(DRAIN_CYC+1) bits.
  - Skew index arithmetic is signed or range-checked; no wrap-around aliasing of out-of-range indices.
- Boundary conditions:
  - res_ready held low indefinitely -> stall in OUT with all outputs stable; no timeout.
  - A start pulse during busy has no effect and is not queued.
  - Reset mid-run returns to IDLE immediately and clears all buffers.
  - done never coincides with res_valid.

Test Plan:
- Reset: assert rst_n = 0 mid-FEED -> outputs go 0 asynchronously; state IDLE; ld_ready = 1 after release.
- Identity: N=4, A = I, B[r][c] = 4r+c+1, start -> arr_valid high exactly 10 cycles; rows returned in order 0..3 with C = B; done pulses once.
- Skew check: A[i][j] = 16i+j, B = 0 -> during FEED k = 3, arr_a = {3, 18, 33, 48}; at k = 0, arr_a = {0, 0, 0, 0} except arr_a[0] = 0x00 (A[0][0]).
- Backpressure: hold res_ready = 0 for 5 cycles at row 1, then toggle it -> res_row/res_data stable while stalled; rows 1, 2, 3 delivered exactly once each.
- Ignored inputs: ld_valid writing A[0][0] = 7 and a start pulse during FEED -> no buffer change and no second run; next run uses the old A[0][0].
- Overflow: all A and B elements = 0xFFFF -> each C element = 4 * 0xFFFE0001 mod 2^32 = 0xFFF80004, passed through unmodified.
